mux_scan_ctrl: RTL and testbench

Sequencing controller for the 32:1 single-bit mux datapath (`mux_32x1frm16x1`). On a start request it steps the mux select through a programmable, optionally wrapping range of inputs. It samples the mux output once per select and assembles the sampled bits into a 32-bit word at their select positions. It sits beside the mux: its `sel` drives the mux select, and the mux `out` returns on `mux_out`.

---
 rtl/mux_scan_ctrl.sv | 92 +++++++++
 tb/tb_mux_scan_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a mux select through a (possibly wrapping) range and packs one sample per select into word
// Optional feature macro: MUX_SCAN_DWELL_EN adds the dwell port and a per-select hold counter.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, abort     scan request (IDLE only) / terminate active scan
//   first_sel        first select of the range, latched on accept
//   last_sel         last select of the range, latched on accept
//   dwell            extra hold cycles per select (MUX_SCAN_DWELL_EN only)
//   mux_out          mux output fed back
//   sel              registered mux select
//   busy, done       scan active / one-cycle pulse after the final sample
//   word             assembled result, bit i sampled with sel=i
module mux_scan_ctrl #(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEL_W-1:0]      first_sel,
    input  logic [SEL_W-1:0]      last_sel,
`ifdef MUX_SCAN_DWELL_EN
    input  logic [DWELL_W-1:0]    dwell,
`endif
    input  logic                  mux_out,
    output logic [SEL_W-1:0]      sel,
    output logic                  busy,
    output logic                  done,
    output logic [2**SEL_W-1:0]   word
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state;
    logic [SEL_W-1:0] last;
    logic [DWELL_W-1:0] cnt;
`ifdef MUX_SCAN_DWELL_EN
    logic [DWELL_W-1:0] d_lat;
`else
    // No dwell: the hold counter is permanently zero, one select per cycle.
    assign cnt = '0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            word  <= '0;
`ifdef MUX_SCAN_DWELL_EN
            cnt   <= '0;
            d_lat <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= SCAN;
                    busy  <= 1'b1;
                    sel   <= first_sel;
                    last  <= last_sel;
                    word  <= '0;
`ifdef MUX_SCAN_DWELL_EN
                    cnt   <= dwell;
                    d_lat <= dwell;
`endif
                end
            end else if (abort) begin
                // abort beats the sample on this edge; sel and word keep their values
                state <= IDLE;
                busy  <= 1'b0;
            end else if (cnt != '0) begin
`ifdef MUX_SCAN_DWELL_EN
                cnt <= cnt - 1'b1;
`endif
            end else begin
                word[sel] <= mux_out;
                if (sel == last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    // natural overflow of sel gives the wrap from N-1 to 0
                    sel <= sel + 1'b1;
`ifdef MUX_SCAN_DWELL_EN
                    cnt <= d_lat;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed self-checking bench for mux_scan_ctrl with a behavioural 32:1 mux
module tb_mux_scan_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, glitch = 1'b0;
    logic [4:0] first_sel = '0, last_sel = '0, sel;
    logic busy, done, mux_out;
    logic [31:0] word, in_v = '0;
`ifdef MUX_SCAN_DWELL_EN
    logic [3:0] dwell = '0;
`endif
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    // glitch corrupts mux_out during hold cycles that must not be sampled
    assign mux_out = in_v[sel] ^ glitch;

    mux_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_sel(first_sel), .last_sel(last_sel),
`ifdef MUX_SCAN_DWELL_EN
        .dwell(dwell),
`endif
        .mux_out(mux_out), .sel(sel), .busy(busy), .done(done), .word(word)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_scan(input logic [4:0] f, input logic [4:0] l, input logic [31:0] v);
        in_v = v;
        first_sel = f;
        last_sel = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input logic [4:0] f, input logic [4:0] l,
                            input logic [31:0] v, input int d, input logic [31:0] exp_word);
        int n;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
`ifdef MUX_SCAN_DWELL_EN
        dwell = 4'(d);
`endif
        begin_scan(f, l, v);
        check({tag, " busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n * (d + 1); i++) begin
            check({tag, " sel"}, 32'(sel), 32'((int'(f) + i / (d + 1)) % 32));
            glitch = (i % (d + 1)) != d;
            tick();
        end
        glitch = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " word"}, word, exp_word);
        tick();
        check({tag, " done fall"}, 32'(done), 32'd0);
        check({tag, " word hold"}, word, exp_word);
        check({tag, " sel hold"}, 32'(sel), 32'(l));
    endtask

    initial begin
        #1;
        check("rst sel", 32'(sel), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst word", word, 32'd0);
        #11 rst = 1'b0;
        tick();

        run_scan("full", 5'd0, 5'd31, 32'h55555555, 0, 32'h55555555);
        run_scan("wrap", 5'd30, 5'd1, 32'hC0000003, 0, 32'hC0000003);
        run_scan("wrap full", 5'd7, 5'd6, 32'h8BADF00D, 0, 32'h8BADF00D);
        run_scan("partial", 5'd4, 5'd11, 32'hFFFFFFFF, 0, 32'h00000FF0);

        // start pulsed while busy must be ignored
        begin_scan(5'd30, 5'd1, 32'hC0000003);
        tick();
        check("ign sel31", 32'(sel), 32'd31);
        first_sel = 5'd10;
        last_sel = 5'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign sel0", 32'(sel), 32'd0);
        tick();
        check("ign sel1", 32'(sel), 32'd1);
        tick();
        check("ign done", 32'(done), 32'd1);
        check("ign word", word, 32'hC0000003);
        tick();

        // single bit, start held through done restarts on the done cycle
        in_v = 32'h00000060;
        first_sel = 5'd5;
        last_sel = 5'd5;
        start = 1'b1;
        tick();
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b sel5", 32'(sel), 32'd5);
        first_sel = 5'd6;
        last_sel = 5'd6;
        tick();
        check("b2b done1", 32'(done), 32'd1);
        check("b2b word1", word, 32'h00000020);
        tick();
        start = 1'b0;
        check("b2b busy2", 32'(busy), 32'd1);
        check("b2b sel6", 32'(sel), 32'd6);
        check("b2b word clr", word, 32'd0);
        check("b2b done low", 32'(done), 32'd0);
        tick();
        check("b2b done2", 32'(done), 32'd1);
        check("b2b word2", word, 32'h00000040);
        tick();

        // abort when sel=8: bits 0..7 kept, no done
        begin_scan(5'd0, 5'd31, 32'hFFFFFFFF);
        repeat (8) tick();
        check("abort sel8", 32'(sel), 32'd8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort word", word, 32'h000000FF);
        check("abort sel", 32'(sel), 32'd8);
        tick();
        check("abort no done", 32'(done), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle abort word", word, 32'h000000FF);
        check("idle abort busy", 32'(busy), 32'd0);

        // asynchronous reset mid-scan
        begin_scan(5'd0, 5'd31, 32'h0F0F0F0F);
        repeat (12) tick();
        check("mid sel12", 32'(sel), 32'd12);
        #2 rst = 1'b1;
        #1;
        check("arst sel", 32'(sel), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst word", word, 32'd0);
        #3 rst = 1'b0;
        tick();
        check("arst still idle", 32'(busy), 32'd0);
        run_scan("post rst", 5'd0, 5'd31, 32'h12345678, 0, 32'h12345678);

`ifdef MUX_SCAN_DWELL_EN
        run_scan("dwell", 5'd0, 5'd31, 32'hA5A5A5A5, 3, 32'hA5A5A5A5);
        run_scan("dwell wrap", 5'd30, 5'd1, 32'hC0000003, 2, 32'hC0000003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
